// File: rtl/div_pkg.sv
// Shared types and constants for the div_seq RV32M divide/remainder sequencer.
package div_pkg;

    localparam int          DIV_ITERS     = 32;
    localparam int          DIV_LATENCY   = 36;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_seq_add_sub.sv
// Shared adder/subtractor: s = x + y when c_in=0, s = x - y when c_in=1.
module div_seq_add_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         c_in_i,
    output logic [W-1:0] s_o,
    output logic         c_out_o
);

    logic [W-1:0] y_eff;

    assign y_eff = y_i ^ {W{c_in_i}};
    assign {c_out_o, s_o} = {1'b0, x_i} + {1'b0, y_eff} + {{W{1'b0}}, c_in_i};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer around one shared adder/subtractor.
// Signed DIV/REM support is enabled by defining DIV_SIGNED_EN.
module div_seq
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

`ifdef DIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;

    logic [XLEN-1:0] add_x, add_y, add_s;
    logic            add_cin, add_cout;
    logic            start_signed;
    logic            accept;
    logic [XLEN-1:0] shifted_rem;
    logic [XLEN-1:0] fix_val;
    logic            fix_neg;

    div_seq_add_sub #(.W(XLEN)) u_add_sub (
        .x_i     (add_x),
        .y_i     (add_y),
        .c_in_i  (add_cin),
        .s_o     (add_s),
        .c_out_o (add_cout)
    );

    assign start_signed = SIGNED_EN & ~op_i[0];
    assign shifted_rem  = {rem_q[XLEN-2:0], a_q[XLEN-1]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        add_x     = '0;
        add_y     = '0;
        add_cin   = 1'b0;
        accept    = 1'b0;
        fix_val   = '0;
        fix_neg   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    rem_d    = '0;
                    cnt_d    = '0;
                    is_rem_d = op_is_rem(div_op_e'(op_i));
                    neg_a_d  = start_signed & a_i[XLEN-1];
                    neg_b_d  = start_signed & b_i[XLEN-1];
                    if (b_i == '0) begin
                        result_d = op_i[1] ? a_i : DIV_BY_ZERO_Q;
                        state_d  = ST_DONE;
                    end else if (start_signed && a_i == DIV_OVF_Q && b_i == '1) begin
                        result_d = op_i[1] ? '0 : DIV_OVF_Q;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_NEG_A;
                    end
                end
            end
            // Pass-through also goes via the adder (x + 0) so one mux feeds a_q.
            ST_NEG_A: begin
                if (neg_a_q) begin
                    add_y   = a_q;
                    add_cin = 1'b1;
                end else begin
                    add_x = a_q;
                end
                a_d     = add_s;
                state_d = ST_NEG_B;
            end
            ST_NEG_B: begin
                if (neg_b_q) begin
                    add_y   = b_q;
                    add_cin = 1'b1;
                end else begin
                    add_x = b_q;
                end
                b_d     = add_s;
                state_d = ST_ITER;
            end
            // Quotient bits shift into the low end of a_q as the dividend shifts out.
            ST_ITER: begin
                add_x   = shifted_rem;
                add_y   = b_q;
                add_cin = 1'b1;
                accept  = rem_q[XLEN-1] | add_cout;
                rem_d   = accept ? add_s : shifted_rem;
                a_d     = {a_q[XLEN-2:0], accept};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix_val = is_rem_q ? rem_q : a_q;
                fix_neg = is_rem_q ? neg_a_q : (neg_a_q ^ neg_b_q);
                if (fix_neg) begin
                    add_y   = fix_val;
                    add_cin = 1'b1;
                end else begin
                    add_x = fix_val;
                end
                result_d = add_s;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush_i && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, busy/reset/flush sequences,
// and randomized ops against an arithmetic reference model.
module tb_div_seq;
    import div_pkg::*;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_seq #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .flush_i  (flush),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_s;
        logic [31:0] exp_u;
        int          lat_s;
        int          lat_u;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bit sgn;
        sgn = SIGNED_EN && !o[0];
        return (y == 0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bit sgn;
        bit rem;
        int sx, sy, r;
        sgn = SIGNED_EN && !o[0];
        rem = o[1];
        sx  = x;
        sy  = y;
        if (y == 0) return rem ? x : 32'hFFFF_FFFF;
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
            r = rem ? (sx % sy) : (sx / sy);
            return r;
        end
        return rem ? (x % y) : (x / y);
    endfunction

    // Launch one op; optionally poke start or flush at a given cycle count after launch.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke_at, input int flush_at, input bit flush_with_start,
                          output logic [31:0] res, output int lat, output bit got_valid,
                          output bit busy_after_flush);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        flush = flush_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat   = 1;
        got_valid = 1'b0;
        busy_after_flush = 1'b0;
        res   = result;
        while (lat <= 60) begin
            if (flush_at > 0 && lat == flush_at + 1) busy_after_flush = busy;
            if (valid) begin
                got_valid = 1'b1;
                res = result;
                break;
            end
            if (lat == poke_at) begin
                start = 1'b1;
                a     = 32'd12345;
                b     = 32'd0;
            end
            if (lat == flush_at) flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            lat++;
        end
        if (got_valid) begin
            @(posedge clk); #1;
        end else begin
            res = result;
        end
    endtask

    initial begin
        logic [31:0] res, exp, prev;
        int          lat, exp_lat;
        bit          gv, baf;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         32'd14,         36, 36});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          32'd2,          36, 36});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'h7FFF_FFFC,  36, 36});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'h1,          36, 36});
        vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1,  1});
        vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          32'd5,          1,  1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1,  36});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1,  36});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0,          36, 36});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'h1,          32'd7,          36, 36});
        vecs.push_back('{2'b00, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1,  1});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFF9,  1,  1});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  36, 36});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h0,          36, 36});

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 1'b0, res, lat, gv, baf);
            exp     = SIGNED_EN ? vecs[i].exp_s : vecs[i].exp_u;
            exp_lat = SIGNED_EN ? vecs[i].lat_s : vecs[i].lat_u;
            $display("vec%0d op=%0d a=%h b=%h -> %h lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d result", i), res, exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("vec%0d idle after", i), 32'(busy), 32'd0);
        end

        // start pulsed while busy must be ignored
        run_op(2'b01, 32'd100, 32'd7, 5, 0, 1'b0, res, lat, gv, baf);
        $display("busy-start DIVU 100/7 -> %h lat=%0d", res, lat);
        check("busy start result", res, 32'd14);
        check("busy start latency", 32'(lat), 32'd36);
        check("busy start no relaunch", 32'(busy), 32'd0);

        // asynchronous reset in the middle of an op
        op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        $display("mid-op reset busy=%0d valid=%0d result=%h", busy, valid, result);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset valid", 32'(valid), 32'd0);
        check("midreset result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'd1000, 32'd3, 0, 0, 1'b0, res, lat, gv, baf);
        $display("post-reset DIVU 1000/3 -> %h lat=%0d", res, lat);
        check("post reset result", res, 32'd333);
        check("post reset latency", 32'(lat), 32'd36);

        // flush at cycle 20: no valid, result held
        prev = 32'd333;
        run_op(2'b01, 32'd50, 32'd5, 0, 20, 1'b0, res, lat, gv, baf);
        $display("flush DIVU 50/5 valid_seen=%0d busy_after=%0d result=%h", gv, baf, res);
        check("flush no valid", 32'(gv), 32'd0);
        check("flush busy drop", 32'(baf), 32'd0);
        check("flush result held", res, prev);

        // flush and start in the same idle cycle: start wins
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 1'b1, res, lat, gv, baf);
        $display("flush+start REMU 100/7 -> %h lat=%0d", res, lat);
        check("flush+start result", res, 32'd2);
        check("flush+start latency", 32'(lat), 32'd36);

        for (int k = 0; k < 60; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 15));
                4:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0, 0, 1'b0, res, lat, gv, baf);
            exp     = model(ro, ra, rb);
            exp_lat = is_special(ro, ra, rb) ? 1 : DIV_LATENCY;
            $display("rand%0d op=%0d a=%h b=%h -> %h lat=%0d", k, ro, ra, rb, res, lat);
            check($sformatf("rand%0d result", k), res, exp);
            check($sformatf("rand%0d latency", k), 32'(lat), 32'(exp_lat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
